wb_rr_arbiter: RTL and testbench
================================

# wb_rr_arbiter

Round-robin arbiter that shares one `WIDTH`-bit result path, built on the existing 5:1 select mux, among five requesters. It grants one requester at a time and drives the 3-bit mux select code so the external mux steers the winner's data. The mux output goes to a single downstream consumer through a valid/ready handshake, and the winning requester gets a one-cycle grant pulse when the transfer completes. The block sits in front of the vector writeback/result path and contains no datapath storage.

## Interface
- `NREQ`, 5: number of requesters. Fixed at 5; any other value is unsupported.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  5: level request, one bit per requester (bit i = input i of the mux).
- `gnt`  out  5: one-hot grant pulse; high for exactly the handshake cycle.
- `sel`  out  3: select code to the 5:1 mux, registered.
- `out_valid`  out  1: mux output holds a granted requester's data, registered.
- `out_ready`  in  1: downstream accepts this cycle.
- `cur_idx`  out  3: index (0-4) of the current owner, for debug/trace; 0 when idle.

## Operation
- States:
  - IDLE: `out_valid`=0.
  - BUSY: `out_valid`=1, owner index latched in `idx`.
- Select encoding, from `idx`:
  - 0→000, 1→001, 2→010, 3→100, 4→110.
  - In IDLE, `sel`=000.
- Round-robin pointer `ptr` (0-4): search order is `ptr`, `ptr+1`, …, `ptr+4`, all mod 5. The first set bit wins.
- IDLE → BUSY: when `req`≠0, latch the winner into `idx`, set `sel` from the encoding, and assert `out_valid` next cycle.
- Handshake: in BUSY with `out_ready`=1, `gnt[idx]`=1 (combinational: `out_valid & out_ready`, one-hot). `ptr` ← (`idx`+1) mod 5, so 4 wraps to 0.
- After a handshake, the next winner is chosen from `req` with bit `idx` masked. This is needed because the finishing requester's `req` is still high in the handshake cycle.
  - Masked `req`≠0: stay in BUSY with the new winner and `idx`/`sel` updated. There is no bubble.
  - Masked `req`=0: return to IDLE, with `sel` ← 000.
- In BUSY without `out_ready`: `idx`, `sel` and `out_valid` hold. `req` changes are ignored.
- Requester contract:
  - Hold `req` and data stable until `gnt`.
  - Drop `req`, or present new data, starting the cycle after `gnt`.
  - Dropping `req` before `gnt` is illegal; the arbiter keeps ownership regardless.
- A single requester with continuous `req` is granted every other transfer at most. It gets back-to-back transfers only when all other bits are 0 and the bubble through IDLE is taken.
- Reset (asynchronous, any state): state=IDLE, `ptr`=0, `idx`=0, `sel`=000, `out_valid`=0, `cur_idx`=0. `gnt`=0, since it is derived from `out_valid`. A transfer in flight is dropped with no grant issued.

## Timing
- Arbitration latency: `req` rises in cycle N while IDLE → `out_valid`/`sel` valid in cycle N+1.
- Earliest grant: N+1, if `out_ready`=1 in N+1.
- Back-to-back: handshake in cycle M with another masked request pending → new owner's `sel`/`out_valid` in M+1. Sustained throughput is 1 transfer/cycle.
- `sel`, `out_valid` and `cur_idx` come from flops. `gnt` is the only combinational output, and depends only on `out_ready` and flop state.
- Reset release: the first arbitration happens on the first rising edge with `rst_n`=1.

## Test plan
- Reset value check:
  - Assert `rst_n`=0 mid-BUSY (owner 3, `out_ready`=0) → immediately `out_valid`=0, `sel`=000, `gnt`=0.
  - After release, `req`=5'b01000 → owner 3, `sel`=100, one cycle later.
- Single request with backpressure: `req`=5'b00100, `out_ready`=0 for 3 cycles then 1 → `sel`=010 held 4 cycles, `gnt`=5'b00100 only in the 4th, then IDLE with `sel`=000.
- Fairness, all requesting: `req`=5'b11111 held (each bit re-raised after its grant), `out_ready`=1 → grant order 0,1,2,3,4,0 with no idle cycles. `sel` sequence is 000,001,010,100,110,000.
- Pointer wrap: `ptr`=4 after granting 3, then `req`=5'b10001 → 4 is granted first (`sel`=110), then 0 (`sel`=000, `out_valid`=1).
- Exclusion of the finisher: owner 2, `req`=5'b00100 only, handshake → IDLE next cycle (`out_valid`=0). `req` still high then → re-granted at `out_valid`=1 one cycle later.
- Idle stability: `req`=0 for 10 cycles with random `out_ready` → `gnt`=0, `out_valid`=0 and `sel`=000 throughout.

Source files
------------

// File: rtl/wb_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// wb_rr_arbiter_if : request/grant and mux-select bundle for wb_rr_arbiter
// Rev 1.0
// ============================================================================
interface wb_rr_arbiter_if #(
  parameter int NREQ = 5
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [2:0]      sel;
  logic [2:0]      cur_idx;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output req,
    output out_ready,
    input  gnt,
    input  sel,
    input  out_valid,
    input  cur_idx
  );

  modport slave (
    input  req,
    input  out_ready,
    output gnt,
    output sel,
    output out_valid,
    output cur_idx
  );
endinterface
`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// wb_rr_arbiter : 5-way round-robin arbiter driving the 5:1 result-path mux
// Rev 1.0
// ============================================================================
module wb_rr_arbiter #(
  parameter int NREQ = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  wb_rr_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_idx;
  logic [2:0]      w_idx_nxt;
  logic [2:0]      r_sel;
  logic [2:0]      w_sel_nxt;
  logic [2:0]      r_ptr;
  logic [2:0]      w_ptr_nxt;
  logic [2:0]      w_base;
  logic [NREQ-1:0] w_cand;
  logic            w_hs;

  function automatic logic [NREQ-1:0] f_onehot(input logic [2:0] i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [2:0] f_inc(input logic [2:0] i);
    return (i == 3'(NREQ - 1)) ? 3'd0 : i + 3'd1;
  endfunction

  // Mux select codes are not binary: 3 and 4 map to 100 and 110.
  function automatic logic [2:0] f_enc(input logic [2:0] i);
    case (i)
      3'd0:    return 3'b000;
      3'd1:    return 3'b001;
      3'd2:    return 3'b010;
      3'd3:    return 3'b100;
      3'd4:    return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] f_pick(input logic [NREQ-1:0] v, input logic [2:0] base);
    logic [2:0] r;
    logic       f;
    int         p;
    r = '0;
    f = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      p = (int'(base) + k) % NREQ;
      if (!f && v[p]) begin
        f = 1'b1;
        r = p[2:0];
      end
    end
    return r;
  endfunction

  assign w_hs = (r_state == S_BUSY) && bus.out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_base      = r_ptr;
    w_cand      = '0;
    case (r_state)
      S_IDLE: w_cand = bus.req;
      S_BUSY: begin
        // The finisher's req is still high in its grant cycle, so mask it.
        if (bus.out_ready) begin
          w_ptr_nxt = f_inc(r_idx);
          w_base    = f_inc(r_idx);
          w_cand    = bus.req & ~f_onehot(r_idx);
        end
      end
      default: w_cand = '0;
    endcase
    if (w_cand != '0) begin
      w_state_nxt = S_BUSY;
      w_idx_nxt   = f_pick(w_cand, w_base);
      w_sel_nxt   = f_enc(w_idx_nxt);
    end else if ((r_state == S_IDLE) || w_hs) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = 3'd0;
      w_sel_nxt   = 3'b000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= 3'd0;
      r_sel   <= 3'b000;
      r_ptr   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign bus.sel       = r_sel;
  assign bus.out_valid = (r_state == S_BUSY);
  assign bus.cur_idx   = r_idx;
  assign bus.gnt       = w_hs ? f_onehot(r_idx) : '0;

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_wb_rr_arbiter : directed + random checks of wb_rr_arbiter against a model
// Rev 1.0
// ============================================================================
module tb_wb_rr_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   m_own;
  int   m_ptr;
  logic [4:0] last_gnt;
  int   sel_tab [5] = '{0, 1, 2, 4, 6};
  int   fair_order [6] = '{0, 1, 2, 3, 4, 0};

  wb_rr_arbiter_if #(.NREQ(5)) bus ();

  wb_rr_arbiter #(.NREQ(5)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [4:0] v, input int base);
    for (int k = 0; k < 5; k++) begin
      if (v[(base + k) % 5]) return (base + k) % 5;
    end
    return -1;
  endfunction

  // Advance the transaction-level model by one clock given this cycle's inputs.
  task automatic model_step(input logic [4:0] r, input logic rdy);
    logic [4:0] masked;
    if (m_own < 0) begin
      if (r != 5'd0) m_own = pick(r, m_ptr);
    end else if (rdy) begin
      m_ptr  = (m_own + 1) % 5;
      masked = r & ~(5'd1 << m_own);
      m_own  = (masked != 5'd0) ? pick(masked, m_ptr) : -1;
    end
  endtask

  task automatic check_outputs(input logic rdy);
    logic       v;
    logic [7:0] e_sel;
    logic [7:0] e_cur;
    logic [7:0] e_gnt;
    v     = (m_own >= 0);
    e_sel = v ? 8'(sel_tab[m_own]) : 8'd0;
    e_cur = v ? 8'(m_own) : 8'd0;
    e_gnt = (v && rdy) ? 8'(1 << m_own) : 8'd0;
    chk("out_valid", 8'(bus.out_valid), 8'(v));
    chk("sel",       8'(bus.sel),       e_sel);
    chk("cur_idx",   8'(bus.cur_idx),   e_cur);
    chk("gnt",       8'(bus.gnt),       e_gnt);
  endtask

  task automatic cycle(input logic [4:0] r, input logic rdy);
    bus.req       = r;
    bus.out_ready = rdy;
    #1;
    check_outputs(rdy);
    last_gnt = bus.gnt;
    model_step(r, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_own = -1;
    m_ptr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [4:0] r;
    logic       rdy;
    n_cmp    = 0;
    n_err    = 0;
    last_gnt = '0;
    bus.req       = '0;
    bus.out_ready = 1'b0;

    // Reset state
    do_reset();
    #1;
    check_outputs(1'b0);

    // Single request with backpressure
    cycle(5'b00100, 1'b0);
    repeat (3) begin
      chk("bp_sel", 8'(bus.sel), 8'b010);
      cycle(5'b00100, 1'b0);
      chk("bp_nogrant", 8'(last_gnt), 8'd0);
    end
    chk("bp_sel4", 8'(bus.sel), 8'b010);
    cycle(5'b00100, 1'b1);
    chk("bp_gnt", 8'(last_gnt), 8'b00100);
    chk("bp_idle_valid", 8'(bus.out_valid), 8'd0);
    chk("bp_idle_sel", 8'(bus.sel), 8'd0);
    cycle(5'b00000, 1'b1);

    // Fairness with everyone requesting, from a fresh pointer
    do_reset();
    @(posedge clk);
    #1;
    cycle(5'b11111, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk("fair_valid", 8'(bus.out_valid), 8'd1);
      chk("fair_sel", 8'(bus.sel), 8'(sel_tab[fair_order[i]]));
      cycle(5'b11111, 1'b1);
      chk("fair_gnt", 8'(last_gnt), 8'(1 << fair_order[i]));
    end
    cycle(5'b00000, 1'b1);

    // Pointer wrap: grant 3, then 10001 -> 4 then 0
    cycle(5'b01000, 1'b1);
    chk("wrap_own3", 8'(bus.cur_idx), 8'd3);
    cycle(5'b11001, 1'b1);
    chk("wrap_sel4", 8'(bus.sel), 8'b110);
    cycle(5'b10001, 1'b1);
    chk("wrap_sel0", 8'(bus.sel), 8'b000);
    chk("wrap_valid0", 8'(bus.out_valid), 8'd1);
    cycle(5'b00001, 1'b1);

    // Finisher excluded: bubble through IDLE, then re-granted
    cycle(5'b00100, 1'b1);
    cycle(5'b00100, 1'b1);
    chk("excl_idle", 8'(bus.out_valid), 8'd0);
    cycle(5'b00100, 1'b1);
    chk("excl_regrant", 8'(bus.out_valid), 8'd1);
    chk("excl_sel", 8'(bus.sel), 8'b010);
    cycle(5'b00000, 1'b1);

    // Idle stability
    for (int i = 0; i < 10; i++) cycle(5'b00000, 1'($urandom_range(0, 1)));

    // Asynchronous reset mid-BUSY with owner 3
    cycle(5'b01000, 1'b0);
    chk("rst_pre_sel", 8'(bus.sel), 8'b100);
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 8'(bus.out_valid), 8'd0);
    chk("rst_async_sel", 8'(bus.sel), 8'd0);
    chk("rst_async_gnt", 8'(bus.gnt), 8'd0);
    m_own = -1;
    m_ptr = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(5'b01000, 1'b0);
    chk("rst_after_sel", 8'(bus.sel), 8'b100);
    cycle(5'b01000, 1'b1);

    // Random traffic, owner's request held until its grant
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      rdy = 1'($urandom_range(0, 2) != 0);
      if (m_own >= 0) r = r | (5'd1 << m_own);
      cycle(r, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
